// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared constants and FSM state type for register_file_mp
package register_file_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREAD  = 2;
    localparam int NREAD_MAX = 4;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one registered read port with zero-register mux and optional write bypass
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rd_en            read accepted this cycle (r_en and not busy)
//   raddr            read address for this port
//   mem_data         array contents at raddr (pre-write)
//   byp_en           a legal write lands this cycle (already excludes x0 and busy)
//   byp_addr         write address
//   byp_data         write data
//   rdata            registered read data
// Bypass forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              byp_en,
    input  logic [ADDR_W-1:0] byp_addr,
    input  logic [DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_data;
`ifdef REGFILE_BYPASS_EN
        if (byp_en && (byp_addr == raddr)) begin
            rdata_d = byp_data;
        end
`endif
        // x0 wins over everything, including forwarded data
        if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata_d = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{byp_en, byp_addr, byp_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - parametrised multi-read-port register file with post-reset clear sequence
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   w_en, rd, write_data   write port (ignored while busy)
//   r_en, raddr      common read enable, packed read addresses
//   rdata, rvalid    packed registered read data, one-cycle read strobe
//   busy             high while the array is being cleared
// Optional write-first bypass: define REGFILE_BYPASS_EN.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NREAD    = RF_NREAD,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [ADDR_W-1:0]       rd,
    input  logic [DATA_W-1:0]       write_data,
    input  logic                    r_en,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    output logic                    rvalid,
    output logic                    busy
);

    localparam int DEPTH = 1 << ADDR_W;

    if ((NREAD < 1) || (NREAD > NREAD_MAX)) begin : g_bad_nread
        $error("register_file_mp: NREAD out of range");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    rf_state_t         state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rvalid_q;

    logic busy_w;
    logic wr_ok;
    logic rd_ok;

    assign busy_w = (state_q == RF_CLEAR);
    // Writes to x0 are discarded when it is hardwired
    assign wr_ok  = w_en && !busy_w && !((ZERO_REG != 0) && (rd == '0));
    assign rd_ok  = r_en && !busy_w;

    // Clear sequencer: walks cnt through every entry, then parks in READY
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                RF_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= RF_READY;
                    end
                end
                default: begin
                    state_q <= RF_READY;
                end
            endcase
        end
    end

    // Array has no reset of its own; the clear sequence zeroes it instead
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy_w) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_ok) begin
                mem_q[rd] <= write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [ADDR_W-1:0] port_addr;
        assign port_addr = raddr[i*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_ok),
            .raddr   (port_addr),
            .mem_data(mem_q[port_addr]),
            .byp_en  (wr_ok),
            .byp_addr(rd),
            .byp_data(write_data),
            .rdata   (rdata[i*DATA_W +: DATA_W])
        );
    end

    assign rvalid = rvalid_q;
    assign busy   = busy_w;

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - randomized scoreboard bench for register_file_mp
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        r_en;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        rvalid;
    logic        busy;

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .rd        (rd),
        .write_data(write_data),
        .r_en      (r_en),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    int          clr_left = 32;
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expv(input logic [4:0] a, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return model[a];
    endfunction

    // One clock of stimulus; model advances with the edge
    task automatic step(input logic rs, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic re,
                        input logic [4:0] a0, input logic [4:0] a1);
        rst = rs; w_en = we; rd = wa; write_data = wd; r_en = re; raddr = {a1, a0};
        if (!rs && clr_left == 0 && re)
            exp_q.push_back({expv(a1, we, wa, wd), expv(a0, we, wa, wd)});
        @(posedge clk);
        if (rs) begin
            clr_left = 32;
            for (int k = 0; k < 32; k++) model[k] = 32'd0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (we && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
        check("busy", {63'd0, busy}, {63'd0, clr_left > 0});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    endtask

    // Monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_unexpected actual=1 required=0 rdata=%h at %0t", rdata, $time);
            end else begin
                check("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        int n;
        logic [4:0] a0, a1, wa;
        rst = 1'b1; w_en = 1'b0; rd = '0; write_data = '0; r_en = 1'b0; raddr = '0;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        check("reset_rdata", rdata, 64'd0);
        check("reset_rvalid", {63'd0, rvalid}, 64'd0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            idle();
            n++;
            check("clear_rdata", rdata, 64'd0);
            check("clear_rvalid", {63'd0, rvalid}, 64'd0);
        end
        check("clear_len", n, 32);
        for (int a = 0; a < 32; a += 2)
            step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(a), 5'(a + 1));

        // Write/read, zero register
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
        check("wr_rd_x5", rdata, {32'hDEADBEEF, 32'hDEADBEEF});
        idle();
        check("rvalid_one_cycle", {63'd0, rvalid}, 64'd0);
        step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd5);
        check("x0_x5", rdata, {32'hDEADBEEF, 32'd0});

        // Same-cycle write/read of x7
        step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_x7", rdata, {2{32'hA5A5A5A5}});
`else
        check("same_cycle_x7", rdata, 64'd0);
`endif
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7);
        check("next_x7", rdata, {2{32'hA5A5A5A5}});

        // Hold behaviour
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 5'd5, 32'h1, 1'b0, 5'd5, 5'd5);
            check("hold_rdata", rdata, {2{32'hDEADBEEF}});
            check("hold_rvalid", {63'd0, rvalid}, 64'd0);
        end

        // Reset mid-clear, write while busy dropped
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) idle();
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 0) step(1'b0, 1'b1, 5'd3, 32'hFF, 1'b1, 5'd3, 5'd3);
            else idle();
            n++;
        end
        check("midclear_len", n, 32);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3);
        check("x3_dropped", rdata, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                wa = 5'($urandom_range(0, 7)); a0 = 5'($urandom_range(0, 7)); a1 = 5'($urandom_range(0, 7));
            end else begin
                wa = 5'($urandom); a0 = 5'($urandom); a1 = 5'($urandom);
            end
            step($urandom_range(0, 199) == 0, 1'($urandom), wa, $urandom,
                 1'($urandom), a0, a1);
        end

        for (int i = 0; i < 3; i++) idle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
